md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide sequencer owning the HI/LO register pair; sits in the E stage beside the ALU.
- Accepts mult/div/mthi/mtlo commands and models fixed multi-cycle latency with a countdown.
- Drives `busy`, which is the HILO_Busy input of the D-stage stall unit, so any HI/LO-touching instruction in D stalls until HI/LO is settled.
- Supplies HI/LO read data to the mfhi/mflo E-stage result path.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for mult/multu (1..15).
- DIV_CYCLES, 10, cycles from start to HI/LO update for div/divu (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- start  in  1  E-stage command valid, sampled each rising edge.
- md_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6/7 reserved (MADD/MSUB, see Optional Feature).
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mt data).
- rt_val  in  32  forwarded rt operand (divisor / multiplier).
- busy  out  1  HI/LO result pending; to stall unit HILO_Busy.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- Reset (async, reset_n=0):
  - hi=0, lo=0, cnt=0, pending result cleared, busy=0.
  - Reset mid-operation discards the in-flight result.
- State: IDLE when cnt==0, RUN when cnt!=0. `cnt` is 4 bits.
- Start of a long op (start & md_op in 0..3, in IDLE):
  - On that edge, latch the 64-bit result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- Results:
  - MULT: signed 32x32 product, {hi,lo}=64-bit product.
  - MULTU: unsigned 32x32 product, {hi,lo}=64-bit product.
  - DIV: signed, lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - DIVU: unsigned, lo=quotient, hi=remainder.
  - Divide by zero: pend = current {hi,lo}, so HI/LO are unchanged after the full latency. busy still asserts normally.
  - Signed overflow 0x80000000/-1: lo=0x80000000, hi=0.
- RUN: cnt decrements each edge. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0.
- Timing:
  - start sampled at end of cycle 0 → new hi/lo visible in cycle N+1.
  - busy is high in cycles 0..N.
- busy = (start & md_op<=3) | (cnt!=0). This is combinational on start, so the instruction in D stalls in the same cycle the op issues.
- MTHI/MTLO (start & md_op 4/5):
  - hi<=rs_val (MTHI) or lo<=rs_val (MTLO) on the next edge; the other register is unchanged.
  - Does not raise busy.
- Start while cnt!=0: ignored, no state change. The stall unit guarantees this never happens; the bench flags it as an error.
- Reserved md_op with start (feature off): ignored.
- hi/lo are direct register outputs; no bypass of the pending value.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined:
  - md_op 6=MADD and 7=MSUB.
  - Signed product computed at start.
  - At commit: {hi,lo} <= {hi,lo} ± product, using the {hi,lo} value at commit time.
  - Latency MULT_CYCLES; busy as for MULT.
- Undefined: codes 6/7 are reserved and ignored; no accumulate adder is synthesised.

Decomposition:
- Shared package holds:
  - the md_op encodings (MD_MULT..MD_MSUB);
  - the default latency constants;
  - the 64-bit result width.
- One natural sub-module: md_calc, purely combinational. It takes md_op, rs_val, rt_val and the current {hi,lo}, and returns the 64-bit pending result, including the divide-by-zero and overflow rules.
- md_unit keeps the counter, the pending registers and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFE(-2), rt=3 at cycle 0:
  - busy high cycles 0..5;
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA first visible in cycle 6.
- DIVU rs=100, rt=7:
  - busy 11 cycles;
  - then lo=14, hi=2.
  - DIV rs=-7, rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=5, rt=0 with hi=0x11, lo=0x22: busy 11 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI rs=0xDEADBEEF, idle: busy never asserts; hi=0xDEADBEEF next cycle; lo unchanged.
- Reset:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF started, reset_n pulsed low at cycle 3;
  - hi=lo=0, busy=0 immediately;
  - no commit afterwards.
- start with MULT while cnt=3: ignored; original result commits on schedule; error flagged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - md_op encodings, default latencies and result width for md_unit
package md_unit_pkg;

  localparam int RES_W           = 64;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit HI/LO result for mult/multu/div/divu (and madd/msub product)
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]       md_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [RES_W-1:0] hilo,
  output logic [RES_W-1:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;
  logic        div_zero;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign rs_mag   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign rt_mag   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign div_zero = (rt_val == 32'd0);
  assign sq_mag   = div_zero ? 32'd0 : rs_mag / rt_mag;
  assign sr_mag   = div_zero ? 32'd0 : rs_mag % rt_mag;
  assign sq       = (rs_val[31] ^ rt_val[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr       = rs_val[31] ? (32'd0 - sr_mag) : sr_mag;

  always_comb begin
    result = hilo;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = div_zero ? hilo : {sr, sq};
      MD_DIVU:  result = div_zero ? hilo : {rs_val % rt_val, rs_val / rt_val};
      MD_MADD,
      MD_MSUB:  result = prod_s;
      default:  result = hilo;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO multiply/divide sequencer with fixed latency; MD_UNIT_MADD_EN enables madd/msub
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [3:0]       cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [RES_W-1:0] calc_res;
  logic [RES_W-1:0] commit_res;
  logic             long_op;
  logic             is_div;

  md_calc u_calc (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hilo   ({hi, lo}),
    .result (calc_res)
  );

  assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

`ifdef MD_UNIT_MADD_EN
  logic pend_acc;
  logic pend_sub;

  assign long_op = start && ((md_op <= MD_DIVU) || (md_op >= MD_MADD));

  // Accumulate uses HI/LO as they stand at commit, not at issue.
  always_comb begin
    commit_res = {pend_hi, pend_lo};
    if (pend_acc)      commit_res = {hi, lo} + {pend_hi, pend_lo};
    else if (pend_sub) commit_res = {hi, lo} - {pend_hi, pend_lo};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_acc <= 1'b0;
      pend_sub <= 1'b0;
    end else if (cnt == 4'd0 && long_op) begin
      pend_acc <= (md_op == MD_MADD);
      pend_sub <= (md_op == MD_MSUB);
    end
  end
`else
  assign long_op    = start && (md_op <= MD_DIVU);
  assign commit_res = {pend_hi, pend_lo};
`endif

  // Combinational on start so the D-stage instruction stalls in the issue cycle.
  assign busy = long_op || (cnt != 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (cnt == 4'd0) begin
      if (long_op) begin
        {pend_hi, pend_lo} <= calc_res;
        cnt                <= is_div ? DIV_LAT : MULT_LAT;
      end else if (start && md_op == MD_MTHI) begin
        hi <= rs_val;
      end else if (start && md_op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) {hi, lo} <= commit_res;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a cycle-numbered behavioural model
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ignored_starts = 0;

  // Model: HI/LO plus one pending result scheduled for an absolute cycle number.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  logic [2:0]  m_kind = 3'd0;
  bit          m_pend = 1'b0;
  int          m_commit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_is_long(input logic [2:0] op);
`ifdef MD_UNIT_MADD_EN
    return (op <= 3'd3) || (op >= 3'd6);
`else
    return (op <= 3'd3);
`endif
  endfunction

  function automatic logic [63:0] m_result(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    longint unsigned ua, ub;
    int ia, ib, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0, 3'd6, 3'd7: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  task automatic compare();
    bit exp_busy;
    exp_busy = (start && m_is_long(md_op)) || m_pend;
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic model_advance();
    bit was_pend;
    was_pend = m_pend;
    if (m_pend && cyc == m_commit) begin
      case (m_kind)
        3'd6: {m_hi, m_lo} = {m_hi, m_lo} + m_res;
        3'd7: {m_hi, m_lo} = {m_hi, m_lo} - m_res;
        default: {m_hi, m_lo} = m_res;
      endcase
      m_pend = 1'b0;
    end
    if (start && m_is_long(md_op)) begin
      if (was_pend) begin
        ignored_starts++;
        $display("note: start while busy at cycle %0d is a stall-unit violation", cyc);
      end else begin
        m_res    = m_result(md_op, rs_val, rt_val, {m_hi, m_lo});
        m_kind   = md_op;
        m_pend   = 1'b1;
        m_commit = cyc + ((md_op == 3'd2 || md_op == 3'd3) ? 10 : 5);
      end
    end else if (start && !was_pend && md_op == 3'd4) begin
      m_hi = rs_val;
    end else if (start && !was_pend && md_op == 3'd5) begin
      m_lo = rs_val;
    end
    cyc++;
  endtask

  // One cycle: drive at the negedge, compare just after, advance the model, wait for the next negedge.
  task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = s;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    compare();
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    start   = 1'b0;
    reset_n = 1'b0;
    #1;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_pend = 1'b0;
    compare();
    @(negedge clk);
    reset_n = 1'b1;
    cyc++;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // MULT -2 * 3
    step(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
    idle(4);
    chk("mult_busy_c5", {31'd0, busy}, 32'd1);
    idle(1);
    chk("mult_busy_c6", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    step(1'b1, MD_DIVU, 32'd100, 32'd7);
    idle(9);
    chk("divu_busy_c10", {31'd0, busy}, 32'd1);
    idle(1);
    chk("divu_busy_c11", {31'd0, busy}, 32'd0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // DIV -7 / 2
    step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero leaves HI/LO alone
    step(1'b1, MD_MTHI, 32'h11, 32'd0);
    step(1'b1, MD_MTLO, 32'h22, 32'd0);
    step(1'b1, MD_DIV, 32'd5, 32'd0);
    idle(9);
    chk("div0_busy_c10", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // MTHI while idle
    start = 1'b1; md_op = MD_MTHI; rs_val = 32'hDEAD_BEEF; #1;
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'h22);

    // Signed overflow
    step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // Reset mid-operation discards the pending product
    step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    idle(8);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Start while cnt=3 is ignored; the original result commits on schedule
    step(1'b1, MD_MULT, 32'd3, 32'd4);
    idle(2);
    step(1'b1, MD_MULT, 32'd7, 32'd7);
    idle(2);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    idle(6);
    chk("ign_lo_late", lo, 32'd12);
    chk("ign_count", ignored_starts, 32'd1);

    // Code 6: reserved by default, MADD when enabled
    step(1'b1, 3'd6, 32'd5, 32'd5);
    idle(6);
`ifdef MD_UNIT_MADD_EN
    chk("op6_lo", lo, 32'd37);
`else
    chk("op6_lo", lo, 32'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
